// File: rtl/seq_controller.sv
// Instruction sequencer: fetches ROM words through rom_reader, executes bus
// write/read, delay, single-level loop and stop. All outputs are registered.
`timescale 1ns/1ps
module seq_controller #(
    parameter int unsigned JMP_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [31:0]          start_addr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [15:0]          rdata_o,
    output logic                 load_start_o,
    output logic                 read_next_o,
    output logic                 jmp_en_o,
    output logic                 jmp_dir_up_o,
    output logic [JMP_WIDTH-1:0] jmp_value_o,
    output logic [31:0]          start_addr_o,
    input  logic [31:0]          rom_data_i,
    input  logic                 rom_data_rdy_i,
    output logic                 bus_req_o,
    output logic                 bus_we_o,
    output logic [11:0]          bus_addr_o,
    output logic [15:0]          bus_wdata_o,
    input  logic [15:0]          bus_rdata_i,
    input  logic                 bus_ack_i
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, BUS, DELAY, DONE} state_t;
    typedef enum logic [3:0] {
        OP_NOP, OP_WRITE, OP_READ, OP_DELAY, OP_LOOP, OP_STOP
    } opcode_t;

    state_t               state, state_nxt;
    opcode_t              opcode;
    logic [31:0]          instr, instr_nxt;
    logic [23:0]          delay_cnt, delay_cnt_nxt;
    logic [7:0]           loop_cnt, loop_cnt_nxt;
    logic [7:0]           loop_rem;
    logic                 loop_active, loop_active_nxt;
    logic                 error, error_nxt;
    logic [15:0]          rdata, rdata_nxt;
    logic                 load_start, load_start_nxt;
    logic                 read_next, read_next_nxt;
    logic                 jmp_en, jmp_en_nxt;
    logic                 jmp_dir_up, jmp_dir_up_nxt;
    logic [JMP_WIDTH-1:0] jmp_value, jmp_value_nxt;
    logic [31:0]          start_addr, start_addr_nxt;
    logic                 bus_req, bus_req_nxt;
    logic                 bus_we, bus_we_nxt;
    logic [11:0]          bus_addr, bus_addr_nxt;
    logic [15:0]          bus_wdata, bus_wdata_nxt;
    logic                 busy, busy_nxt;
    logic                 done, done_nxt;
    logic                 step, jump;

    assign opcode   = opcode_t'(instr[31:28]);
    assign loop_rem = loop_active ? loop_cnt : instr[27:20];

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state       <= IDLE;
            instr       <= '0;
            delay_cnt   <= '0;
            loop_cnt    <= '0;
            loop_active <= 1'b0;
            error       <= 1'b0;
            rdata       <= '0;
            load_start  <= 1'b0;
            read_next   <= 1'b0;
            jmp_en      <= 1'b0;
            jmp_dir_up  <= 1'b0;
            jmp_value   <= '0;
            start_addr  <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            instr       <= instr_nxt;
            delay_cnt   <= delay_cnt_nxt;
            loop_cnt    <= loop_cnt_nxt;
            loop_active <= loop_active_nxt;
            error       <= error_nxt;
            rdata       <= rdata_nxt;
            load_start  <= load_start_nxt;
            read_next   <= read_next_nxt;
            jmp_en      <= jmp_en_nxt;
            jmp_dir_up  <= jmp_dir_up_nxt;
            jmp_value   <= jmp_value_nxt;
            start_addr  <= start_addr_nxt;
            bus_req     <= bus_req_nxt;
            bus_we      <= bus_we_nxt;
            bus_addr    <= bus_addr_nxt;
            bus_wdata   <= bus_wdata_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        instr_nxt       = instr;
        delay_cnt_nxt   = delay_cnt;
        loop_cnt_nxt    = loop_cnt;
        loop_active_nxt = loop_active;
        error_nxt       = error;
        rdata_nxt       = rdata;
        load_start_nxt  = 1'b0;
        read_next_nxt   = 1'b0;
        jmp_en_nxt      = 1'b0;
        jmp_dir_up_nxt  = 1'b0;
        jmp_value_nxt   = '0;
        start_addr_nxt  = start_addr;
        bus_req_nxt     = bus_req;
        bus_we_nxt      = bus_we;
        bus_addr_nxt    = bus_addr;
        bus_wdata_nxt   = bus_wdata;
        step            = 1'b0;
        jump            = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    start_addr_nxt = start_addr_i;
                    load_start_nxt = 1'b1;
                    error_nxt      = 1'b0;
                    state_nxt      = FETCH;
                end
            end
            FETCH: begin
                if (rom_data_rdy_i) begin
                    instr_nxt = rom_data_i;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                case (opcode)
                    OP_NOP: step = 1'b1;
                    OP_WRITE, OP_READ: begin
                        bus_req_nxt   = 1'b1;
                        bus_we_nxt    = (opcode == OP_WRITE);
                        bus_addr_nxt  = instr[27:16];
                        bus_wdata_nxt = instr[15:0];
                        state_nxt     = BUS;
                    end
                    OP_DELAY: begin
                        if (instr[23:0] == '0) begin
                            step = 1'b1;
                        end else begin
                            delay_cnt_nxt = instr[23:0];
                            state_nxt     = DELAY;
                        end
                    end
                    OP_LOOP: begin
                        if (loop_rem != '0) begin
                            jump            = 1'b1;
                            loop_cnt_nxt    = loop_rem - 8'd1;
                            loop_active_nxt = 1'b1;
                        end else begin
                            loop_active_nxt = 1'b0;
                            step            = 1'b1;
                        end
                    end
                    OP_STOP: state_nxt = DONE;
                    default: begin
                        error_nxt = 1'b1;
                        state_nxt = DONE;
                    end
                endcase
            end
            BUS: begin
                if (bus_ack_i) begin
                    bus_req_nxt = 1'b0;
                    if (!bus_we) rdata_nxt = bus_rdata_i;
                    step = 1'b1;
                end
            end
            DELAY: begin
                if (delay_cnt == 24'd1) step = 1'b1;
                else delay_cnt_nxt = delay_cnt - 24'd1;
            end
            default: state_nxt = IDLE;
        endcase

        if (step || jump) begin
            read_next_nxt = 1'b1;
            jmp_en_nxt    = jump;
            state_nxt     = FETCH;
            if (jump) begin
                jmp_dir_up_nxt = instr[12];
                jmp_value_nxt  = instr[JMP_WIDTH-1:0];
            end
        end

        // abort overrides every decision above, but keeps error/rdata/start_addr
        if (abort_i) begin
            state_nxt       = IDLE;
            bus_req_nxt     = 1'b0;
            loop_active_nxt = 1'b0;
            load_start_nxt  = 1'b0;
            read_next_nxt   = 1'b0;
            jmp_en_nxt      = 1'b0;
            jmp_dir_up_nxt  = 1'b0;
            jmp_value_nxt   = '0;
            error_nxt       = error;
            rdata_nxt       = rdata;
            start_addr_nxt  = start_addr;
        end

        busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
        done_nxt = (state_nxt == DONE);
    end

    assign busy_o       = busy;
    assign done_o       = done;
    assign error_o      = error;
    assign rdata_o      = rdata;
    assign load_start_o = load_start;
    assign read_next_o  = read_next;
    assign jmp_en_o     = jmp_en;
    assign jmp_dir_up_o = jmp_dir_up;
    assign jmp_value_o  = jmp_value;
    assign start_addr_o = start_addr;
    assign bus_req_o    = bus_req;
    assign bus_we_o     = bus_we;
    assign bus_addr_o   = bus_addr;
    assign bus_wdata_o  = bus_wdata;

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: ROM/rom_reader and bus slave models, expected
// bus, jump and completion events queued by stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_seq_controller;
    localparam int unsigned JW = 8;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   start_addr = '0;
    logic          busy_o, done_o, error_o;
    logic [15:0]   rdata_o;
    logic          load_start_o, read_next_o, jmp_en_o, jmp_dir_up_o;
    logic [JW-1:0] jmp_value_o;
    logic [31:0]   start_addr_o;
    logic [31:0]   rom_data = '0;
    logic          rom_rdy = 1'b0;
    logic          bus_req_o, bus_we_o;
    logic [11:0]   bus_addr_o;
    logic [15:0]   bus_wdata_o;
    logic [15:0]   bus_rdata = 16'h1234;
    logic          ack = 1'b0;

    always #5 clk = ~clk;

    seq_controller #(.JMP_WIDTH(JW)) dut (
        .clk_i(clk), .nrst_i(nrst), .start_i(start), .abort_i(abort),
        .start_addr_i(start_addr), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .rdata_o(rdata_o), .load_start_o(load_start_o),
        .read_next_o(read_next_o), .jmp_en_o(jmp_en_o),
        .jmp_dir_up_o(jmp_dir_up_o), .jmp_value_o(jmp_value_o),
        .start_addr_o(start_addr_o), .rom_data_i(rom_data),
        .rom_data_rdy_i(rom_rdy), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata), .bus_ack_i(ack)
    );

    typedef struct packed { logic we; logic [11:0] addr; logic [15:0] data; } bus_t;
    typedef struct packed { logic dir_up; logic [JW-1:0] value; } jmp_t;
    typedef struct packed { logic error; logic [15:0] rdata; } end_t;

    bus_t exp_bus[$];
    jmp_t exp_jmp[$];
    end_t exp_end[$];
    bus_t eb;
    jmp_t ej;
    end_t ee;

    int total = 0, bad = 0;
    int n_bus = 0, n_jmp = 0, n_step = 0;
    logic prev_req = 1'b0, prev_done = 1'b0;
    logic hold_ack = 1'b0;
    logic [31:0] rom [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: event with no queued expectation", name);
    endtask

    // rom_reader model: rdy one cycle, two cycles after a load/step/jump pulse
    initial begin : rom_model
        logic [3:0] addr;
        int pend;
        addr = '0;
        pend = 0;
        forever begin
            @(posedge clk); #1;
            rom_rdy = 1'b0;
            if (!nrst) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        rom_rdy  = 1'b1;
                        rom_data = rom[addr];
                    end
                end
                if (load_start_o) begin
                    addr = start_addr_o[3:0];
                    pend = 2;
                end else if (read_next_o) begin
                    if (jmp_en_o)
                        addr = jmp_dir_up_o ? addr + jmp_value_o[3:0] : addr - jmp_value_o[3:0];
                    else
                        addr = addr + 4'd1;
                    pend = 2;
                end
            end
        end
    end

    initial begin : bus_slave
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk); #1;
            ack = 1'b0;
            if (bus_req_o && !hold_ack) begin
                wait_cnt++;
                if (wait_cnt == 3) begin
                    ack = 1'b1;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (nrst) begin
            if (bus_req_o && !prev_req) begin
                n_bus++;
                if (exp_bus.size() == 0) flag("bus_txn");
                else begin
                    eb = exp_bus.pop_front();
                    check("bus_we", bus_we_o, eb.we);
                    check("bus_addr", bus_addr_o, eb.addr);
                    if (eb.we) check("bus_wdata", bus_wdata_o, eb.data);
                end
            end
            if (read_next_o) begin
                check("pulse_overlap", load_start_o, 0);
                if (jmp_en_o) begin
                    n_jmp++;
                    if (exp_jmp.size() == 0) flag("jump");
                    else begin
                        ej = exp_jmp.pop_front();
                        check("jmp_dir", jmp_dir_up_o, ej.dir_up);
                        check("jmp_value", jmp_value_o, ej.value);
                    end
                end else begin
                    n_step++;
                end
            end else if (jmp_en_o) begin
                check("jmp_en_qual", jmp_en_o, 0);
            end
            if (done_o && !prev_done) begin
                if (exp_end.size() == 0) flag("done");
                else begin
                    ee = exp_end.pop_front();
                    check("end_error", error_o, ee.error);
                    check("end_rdata", rdata_o, ee.rdata);
                    check("end_busy", busy_o, 0);
                end
            end
        end
        prev_req  = bus_req_o;
        prev_done = done_o;
    end

    task automatic kick(input logic [31:0] addr);
        @(posedge clk); #1;
        start_addr = addr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cycles);
        int n;
        n = 0;
        while (!done_o && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done"}, done_o, 1);
        cycles = n;
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, {busy_o, done_o, error_o, load_start_o, read_next_o,
                              jmp_en_o, jmp_dir_up_o, bus_req_o, bus_we_o}, 0);
        check({name, "_rdata"}, rdata_o, 0);
        check({name, "_jmpval"}, jmp_value_o, 0);
        check({name, "_saddr"}, start_addr_o, 0);
        check({name, "_bus"}, {bus_addr_o, bus_wdata_o}, 0);
    endtask

    initial begin : main
        int c_nop, c_del, c, nb0, nj0, ns0, n;
        for (int i = 0; i < 16; i++) rom[i] = 32'h0000_0000;
        rom[1]  = 32'h5000_0000;
        rom[4]  = 32'h1010_BEEF;
        rom[5]  = 32'h2020_0000;
        rom[6]  = 32'h5000_0000;
        rom[8]  = 32'h3000_0005;
        rom[9]  = 32'h5000_0000;
        rom[10] = 32'h1030_0055;
        rom[11] = 32'h4030_0001;
        rom[12] = 32'h5000_0000;
        rom[13] = 32'hF000_0000;
        rom[14] = 32'h1040_1111;
        rom[15] = 32'h5000_0000;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        nrst = 1'b1;

        // write/read/stop program
        nb0 = n_bus;
        exp_bus.push_back(bus_t'{we: 1'b1, addr: 12'h010, data: 16'hBEEF});
        exp_bus.push_back(bus_t'{we: 1'b0, addr: 12'h020, data: 16'h0000});
        exp_end.push_back(end_t'{error: 1'b0, rdata: 16'h1234});
        kick(32'd4);
        check("t1_load_pulse", load_start_o, 1);
        check("t1_start_addr", start_addr_o, 32'd4);
        check("t1_busy", busy_o, 1);
        wait_done("t1", c);
        check("t1_bus_count", n_bus - nb0, 2);
        check("t1_rdata", rdata_o, 16'h1234);
        check("t1_error", error_o, 0);

        // NOP vs DELAY 5
        exp_end.push_back(end_t'{error: 1'b0, rdata: 16'h1234});
        exp_end.push_back(end_t'{error: 1'b0, rdata: 16'h1234});
        kick(32'd0);
        wait_done("nop", c_nop);
        kick(32'd8);
        wait_done("delay", c_del);
        check("delay_extra", c_del - c_nop, 5);

        // loop C=3 back by one word
        nb0 = n_bus; nj0 = n_jmp; ns0 = n_step;
        for (int i = 0; i < 4; i++)
            exp_bus.push_back(bus_t'{we: 1'b1, addr: 12'h030, data: 16'h0055});
        for (int i = 0; i < 3; i++)
            exp_jmp.push_back(jmp_t'{dir_up: 1'b0, value: 8'd1});
        exp_end.push_back(end_t'{error: 1'b0, rdata: 16'h1234});
        kick(32'd10);
        wait_done("loop", c);
        check("loop_writes", n_bus - nb0, 4);
        check("loop_jumps", n_jmp - nj0, 3);
        check("loop_steps", n_step - ns0, 5);
        check("loop_active_end", dut.loop_active, 0);

        // illegal opcode, then restart clears error
        exp_end.push_back(end_t'{error: 1'b1, rdata: 16'h1234});
        kick(32'd13);
        wait_done("illegal", c);
        check("illegal_error", error_o, 1);
        exp_end.push_back(end_t'{error: 1'b0, rdata: 16'h1234});
        kick(32'd0);
        check("restart_error_clr", error_o, 0);
        wait_done("restart", c);

        // abort during BUS with ack withheld, start held alongside abort
        hold_ack = 1'b1;
        exp_bus.push_back(bus_t'{we: 1'b1, addr: 12'h040, data: 16'h1111});
        kick(32'd14);
        n = 0;
        while (!bus_req_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_req_seen", bus_req_o, 1);
        @(posedge clk); #1;
        abort = 1'b1;
        start = 1'b1;
        start_addr = 32'd0;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_req_drop", bus_req_o, 0);
        check("abort_idle", {busy_o, done_o}, 0);
        check("abort_no_load", load_start_o, 0);
        check("abort_rdata", rdata_o, 16'h1234);
        check("abort_error", error_o, 0);
        check("abort_saddr", start_addr_o, 32'd14);
        hold_ack = 1'b0;

        // start while busy is ignored
        exp_end.push_back(end_t'{error: 1'b0, rdata: 16'h1234});
        kick(32'd8);
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_no_load", load_start_o, 0);
        check("busy_saddr", start_addr_o, 32'd8);
        wait_done("busy_start", c);

        // async reset in the middle of DELAY
        kick(32'd8);
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_busy", busy_o, 1);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;

        check("exp_bus_left", exp_bus.size(), 0);
        check("exp_jmp_left", exp_jmp.size(), 0);
        check("exp_end_left", exp_end.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
